// File: rtl/hdmi_src.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_src
// Brief    : Test-pattern video source producing HDMI-style vs/hs/de/data
//            framing with configurable active area, blanking and 4 patterns.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_src #(
    parameter int H_ACTIVE = 64,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 64,
    parameter int V_BLANK  = 4
) (
    input  logic        hdmi_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        hdmi_vs,
    output logic        hdmi_hs,
    output logic        hdmi_de,
    output logic [31:0] hdmi_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int c_H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int c_V_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int c_HW      = (c_H_TOTAL > 1) ? $clog2(c_H_TOTAL) : 1;
    localparam int c_LW      = (c_V_MAX > 1) ? $clog2(c_V_MAX) : 1;

    localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_BLANK_W = c_HW'(H_BLANK);
    localparam logic [c_LW-1:0] c_VB_LAST   = c_LW'(V_BLANK - 1);
    localparam logic [c_LW-1:0] c_VA_LAST   = c_LW'(V_ACTIVE - 1);
    localparam logic [23:0]     c_LFSR_SEED = 24'h5A5A5A;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_HW-1:0]   h_q, h_d;
    logic [c_LW-1:0]   line_q, line_d;
    logic              enable_q, enable_d;
    logic [1:0]        pat_q, pat_d;
    logic [23:0]       solid_q, solid_d;
    logic [23:0]       lfsr_q, lfsr_d;
    logic              end_q, end_d;
    logic              vs_q, vs_d;
    logic              hs_q, hs_d;
    logic              de_q, de_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              w_h_last;
    logic              w_in_blank;
    logic              w_pix;
    logic [7:0]        w_x;
    logic [7:0]        w_y;
    logic              w_fb;
    logic [23:0]       w_rgb;

    assign w_h_last   = (h_q == c_H_LAST);
    assign w_in_blank = (h_q < c_H_BLANK_W);
    assign w_pix      = (state_q == S_ACTIVE) && !w_in_blank;
    assign w_x        = 8'(h_q - c_H_BLANK_W);
    assign w_y        = 8'(line_q);
    assign w_fb       = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        line_d   = line_q;
        enable_d = enable;
        pat_d    = pat_q;
        solid_d  = solid_q;
        lfsr_d   = lfsr_q;
        end_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                h_d    = '0;
                line_d = '0;
                if (enable_q) begin
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (w_h_last) begin
                    h_d = '0;
                    if (line_q == c_VB_LAST) begin
                        line_d = '0;
                        // Frame boundary: the only point where run request and pattern controls take effect
                        if (enable_q) begin
                            state_d = S_ACTIVE;
                            pat_d   = pattern_sel;
                            solid_d = solid_rgb;
                            lfsr_d  = c_LFSR_SEED;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        line_d = line_q + c_LW'(1);
                    end
                end else begin
                    h_d = h_q + c_HW'(1);
                end
            end
            S_ACTIVE: begin
                if (w_pix) begin
                    lfsr_d = {lfsr_q[22:0], w_fb};
                end
                if (w_h_last) begin
                    h_d = '0;
                    if (line_q == c_VA_LAST) begin
                        line_d  = '0;
                        state_d = S_VBLANK;
                        end_d   = 1'b1;
                    end else begin
                        line_d = line_q + c_LW'(1);
                    end
                end else begin
                    h_d = h_q + c_HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                h_d     = '0;
                line_d  = '0;
            end
        endcase
    end

    always_comb begin
        w_rgb = 24'h000000;
        case (pat_q)
            2'd0:    w_rgb = {w_x, w_y, cnt_q};
            2'd1:    w_rgb = {24{w_x[3] ^ w_y[3]}};
            2'd2:    w_rgb = solid_q;
            default: w_rgb = lfsr_q;
        endcase
    end

    // Frame completion is reported one cycle after the last pixel so it lines up with the vs fall
    always_comb begin
        vs_d   = (state_q == S_ACTIVE);
        hs_d   = (state_q != S_IDLE) && w_in_blank;
        de_d   = w_pix;
        data_d = w_pix ? {8'h00, w_rgb} : 32'h0;
        done_d = end_q;
        cnt_d  = end_q ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge hdmi_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            line_q   <= '0;
            enable_q <= 1'b0;
            pat_q    <= 2'd0;
            solid_q  <= 24'h000000;
            lfsr_q   <= c_LFSR_SEED;
            end_q    <= 1'b0;
            vs_q     <= 1'b0;
            hs_q     <= 1'b0;
            de_q     <= 1'b0;
            data_q   <= 32'h0;
            done_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            line_q   <= line_d;
            enable_q <= enable_d;
            pat_q    <= pat_d;
            solid_q  <= solid_d;
            lfsr_q   <= lfsr_d;
            end_q    <= end_d;
            vs_q     <= vs_d;
            hs_q     <= hs_d;
            de_q     <= de_d;
            data_q   <= data_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign hdmi_vs    = vs_q;
    assign hdmi_hs    = hs_q;
    assign hdmi_de    = de_q;
    assign hdmi_data  = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_src
// Brief    : Self-checking bench for hdmi_src: frame timing, patterns,
//            enable handling and reset against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_src;

    localparam int H_ACTIVE = 64;
    localparam int H_BLANK  = 16;
    localparam int V_ACTIVE = 64;
    localparam int V_BLANK  = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int NPIX     = H_ACTIVE * V_ACTIVE;
    localparam int LAT      = 2 + V_BLANK * H_TOTAL;

    logic        hdmi_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        hdmi_vs, hdmi_hs, hdmi_de, frame_done;
    logic [31:0] hdmi_data;
    logic [7:0]  frame_cnt;

    hdmi_src #(.H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE), .V_BLANK(V_BLANK)) dut (
        .hdmi_clk(hdmi_clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .hdmi_vs(hdmi_vs), .hdmi_hs(hdmi_hs), .hdmi_de(hdmi_de),
        .hdmi_data(hdmi_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_edge = 1'b1;

    always @(posedge hdmi_clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Reference LFSR sequence built straight from the polynomial
    logic [23:0] ref_lfsr [NPIX];
    initial begin
        logic [23:0] s;
        s = 24'h5A5A5A;
        for (int i = 0; i < NPIX; i++) begin
            ref_lfsr[i] = s;
            s = {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
        end
    end

    function automatic logic [31:0] exp_pix(input int pat, input logic [23:0] sol, input int x, input int y, input int fc);
        case (pat)
            0:       return {8'h00, 8'(x), 8'(y), 8'(fc)};
            1:       return (((x ^ y) & 8) != 0) ? 32'h00FFFFFF : 32'h0;
            2:       return {8'h00, sol};
            default: return {8'h00, ref_lfsr[y * H_ACTIVE + x]};
        endcase
    endfunction

    // ---------------- monitor / frame-level model ----------------
    logic        prev_vs = 1'b0, prev_de = 1'b0, prev_hs = 1'b0;
    int          n_rise = 0, n_fall = 0, n_done = 0, mf = 0;
    int          rise_cyc = 0, prev_rise_cyc = 0, fall_cyc = 0, first_de_cyc = 0, last_hs_cyc = 0;
    int          vs_high_len = 0, vs_low_len = 0, period = 0;
    int          line_cnt = 0, de_run = 0, hs_run = 0, pix = 0, frame_bad = 0, bad_runs = 0;
    int          fr_lines = 0, fr_bad = 0, fr_pix = 0, fr_runs_bad = 0, same_prev = 0;
    logic [31:0] fr_first = '0, fr_last = '0;
    int          viol_de = 0, viol_data = 0, viol_hs = 0, viol_done = 0;
    int          cur_pat = 0;
    logic [23:0] cur_sol = '0;
    logic [31:0] cur_frame [NPIX];
    logic [31:0] last_frame [NPIX];

    always @(negedge hdmi_clk) begin
        if (hdmi_de && !hdmi_vs) viol_de++;
        if (!hdmi_de && hdmi_data !== 32'h0) viol_data++;
        if (hdmi_hs && hdmi_de) viol_hs++;
        if (frame_done !== (prev_vs && !hdmi_vs && !rst_edge)) viol_done++;
        if (frame_done) n_done++;
        if (rst_edge) mf = 0;
        if (hdmi_hs) last_hs_cyc = cyc;

        if (hdmi_vs && !prev_vs) begin
            if (hdmi_de) viol_de++;
            n_rise++;
            prev_rise_cyc = rise_cyc;
            rise_cyc   = cyc;
            period     = rise_cyc - prev_rise_cyc;
            vs_low_len = cyc - fall_cyc;
            line_cnt = 0; de_run = 0; pix = 0; frame_bad = 0; bad_runs = 0;
            cur_pat = int'(pattern_sel);
            cur_sol = solid_rgb;
        end

        if (hdmi_de) begin
            if (pix == 0) first_de_cyc = cyc;
            if (pix < NPIX) begin
                cur_frame[pix] = hdmi_data;
                if (hdmi_data !== exp_pix(cur_pat, cur_sol, de_run, line_cnt, mf)) frame_bad++;
            end
            pix++;
            de_run++;
        end else if (prev_de) begin
            line_cnt++;
            if (de_run != H_ACTIVE) bad_runs++;
            de_run = 0;
        end

        if (hdmi_hs) hs_run++;
        else if (prev_hs) begin
            if (!rst_edge && hs_run != H_BLANK) viol_hs++;
            hs_run = 0;
        end

        if (!hdmi_vs && prev_vs) begin
            if (hdmi_de) viol_de++;
            if (!rst_edge) begin
                n_fall++;
                fall_cyc    = cyc;
                vs_high_len = cyc - rise_cyc;
                fr_lines    = line_cnt;
                fr_bad      = frame_bad;
                fr_pix      = pix;
                fr_runs_bad = bad_runs;
                fr_first    = cur_frame[0];
                fr_last     = (pix > 0 && pix <= NPIX) ? cur_frame[pix-1] : 32'hDEADBEEF;
                same_prev   = 1;
                for (int i = 0; i < NPIX; i++) begin
                    if (cur_frame[i] !== last_frame[i]) same_prev = 0;
                    last_frame[i] = cur_frame[i];
                end
                mf++;
            end
        end

        prev_vs = hdmi_vs;
        prev_de = hdmi_de;
        prev_hs = hdmi_hs;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge hdmi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_rise(input int target, input string tag);
        int n = 0;
        while (n_rise < target && n < 7000) begin step(); n++; end
        chk(tag, (n_rise >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_fall(input int target, input string tag);
        int n = 0;
        while (n_fall < target && n < 7000) begin step(); n++; end
        chk(tag, (n_fall >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_line(input int target, input string tag);
        int n = 0;
        while (line_cnt < target && n < 7000) begin step(); n++; end
        chk(tag, (line_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    bit seen [logic [23:0]];

    // ---------------- directed sequence ----------------
    initial begin
        int k, f, dups, snap;

        rst = 1'b1;
        repeat (3) step();
        chk("reset_ctl", {28'd0, hdmi_vs, hdmi_hs, hdmi_de, frame_done}, 32'd0);
        chk("reset_data", hdmi_data, 32'd0);
        chk("reset_cnt", {24'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        repeat ($urandom_range(1, 20)) step();

        // Pattern 0, three continuous frames
        pattern_sel = 2'd0;
        enable = 1'b1;
        k = cyc + 1;
        wait_rise(1, "rise0_timeout");
        chk("vs_latency", rise_cyc, k + LAT);
        repeat (H_BLANK + 2) step();
        chk("de_latency", first_de_cyc, k + LAT + H_BLANK);
        wait_fall(1, "fall0_timeout");
        chk("f0_lines", fr_lines, V_ACTIVE);
        chk("f0_runs", fr_runs_bad, 0);
        chk("f0_npix", fr_pix, NPIX);
        chk("f0_bad", fr_bad, 0);
        chk("f0_first", fr_first, 32'h00000000);
        chk("f0_last", fr_last, 32'h003F3F00);
        chk("vs_high", vs_high_len, V_ACTIVE * H_TOTAL);
        wait_fall(2, "fall1_timeout");
        chk("f1_first", fr_first, 32'h00000001);
        chk("f1_bad", fr_bad, 0);
        chk("vs_low", vs_low_len, V_BLANK * H_TOTAL);
        chk("period", period, H_TOTAL * (V_ACTIVE + V_BLANK));
        wait_fall(3, "fall2_timeout");
        chk("done_pulses", n_done, 3);
        chk("frame_cnt3", {24'd0, frame_cnt}, 32'd3);

        // Checker switched to solid mid-frame
        pattern_sel = 2'd1;
        wait_rise(4, "rise3_timeout");
        wait_line(10, "line10_timeout");
        pattern_sel = 2'd2;
        solid_rgb   = 24'h123456;
        wait_fall(4, "fall3_timeout");
        chk("chk_bad", fr_bad, 0);
        chk("chk_x8y0", last_frame[8], 32'h00FFFFFF);
        chk("chk_x8y8", last_frame[8 * H_ACTIVE + 8], 32'h00000000);
        wait_fall(5, "fall4_timeout");
        chk("solid_bad", fr_bad, 0);
        chk("solid_first", last_frame[0], 32'h00123456);
        chk("solid_last", last_frame[NPIX-1], 32'h00123456);

        // LFSR noise over two frames
        pattern_sel = 2'd3;
        wait_fall(6, "fall5_timeout");
        chk("lfsr0_bad", fr_bad, 0);
        chk("lfsr0_first", fr_first, 32'h005A5A5A);
        wait_fall(7, "fall6_timeout");
        chk("lfsr1_bad", fr_bad, 0);
        chk("lfsr1_first", fr_first, 32'h005A5A5A);
        chk("lfsr_same", same_prev, 1);
        dups = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (seen.exists(last_frame[i][23:0])) dups++;
            else seen[last_frame[i][23:0]] = 1'b1;
        end
        chk("lfsr_dups", dups, 0);

        // Random solid colour; enable dropped at line 10
        pattern_sel = 2'd2;
        solid_rgb   = 24'($urandom);
        wait_rise(8, "rise7_timeout");
        wait_line(10, "drop_timeout");
        enable = 1'b0;
        wait_fall(8, "fall7_timeout");
        chk("drop_lines", fr_lines, V_ACTIVE);
        chk("drop_bad", fr_bad, 0);
        f = fall_cyc;
        repeat (V_BLANK * H_TOTAL + 10) step();
        chk("drop_last_hs", last_hs_cyc, f + (V_BLANK - 1) * H_TOTAL + H_BLANK - 1);
        chk("idle_norise", n_rise, 8);
        chk("idle_ctl", {28'd0, hdmi_vs, hdmi_hs, hdmi_de, frame_done}, 32'd0);
        chk("idle_data", hdmi_data, 32'd0);
        chk("cnt_model", {24'd0, frame_cnt}, mf);

        // Re-enable, then reset in the middle of the frame
        repeat ($urandom_range(5, 50)) step();
        pattern_sel = 2'd0;
        enable = 1'b1;
        k = cyc + 1;
        wait_rise(9, "rise8_timeout");
        chk("reen_latency", rise_cyc, k + LAT);
        wait_line(30, "line30_timeout");
        snap = n_done;
        rst = 1'b1;
        step();
        chk("rst_ctl", {28'd0, hdmi_vs, hdmi_hs, hdmi_de, frame_done}, 32'd0);
        chk("rst_data", hdmi_data, 32'd0);
        chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        enable = 1'b0;
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("rst_nodone", n_done, snap);
        chk("rst_idle", {31'd0, hdmi_vs}, 32'd0);

        chk("viol_de", viol_de, 0);
        chk("viol_data", viol_data, 0);
        chk("viol_hs", viol_hs, 0);
        chk("viol_done", viol_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
